// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first,
// holding each bit for BIT_CYCLES clocks, with optional idle gaps between passes.
module seq_pattern_gen #(
  parameter int PAT_MAX    = 8,
  parameter int BIT_CYCLES = 2,
  parameter int GAP_CYCLES = 0,
  parameter int REP_W      = 4
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [PAT_MAX-1:0]             i_pattern,
  input  logic [$clog2(PAT_MAX+1)-1:0]   i_len,
  input  logic [REP_W-1:0]               i_repeat,
  output logic                           o_bit,
  output logic                           o_valid,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int LW   = $clog2(PAT_MAX + 1);
  localparam int IW   = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam int CMAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0]    BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0]    GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LW-1:0]    LEN_MAX  = LW'(PAT_MAX);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [PAT_MAX-1:0] pat_reg, pat_next;
  logic [LW-1:0]      len_reg, len_next;
  logic [REP_W-1:0]   rep_reg, rep_next;
  logic [IW-1:0]      bit_reg, bit_next;
  logic [CW-1:0]      cyc_reg, cyc_next;

  logic [LW-1:0]      eff_len;
  logic [IW-1:0]      bit_reload;

  assign eff_len    = (i_len > LEN_MAX) ? LEN_MAX : i_len;
  assign bit_reload = IW'(len_reg - 1'b1);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg <= S_IDLE;
      pat_reg   <= '0;
      len_reg   <= '0;
      rep_reg   <= '0;
      bit_reg   <= '0;
      cyc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      rep_reg   <= rep_next;
      bit_reg   <= bit_next;
      cyc_reg   <= cyc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    rep_next   = rep_reg;
    bit_next   = bit_reg;
    cyc_next   = cyc_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (i_start && (i_len != '0)) begin
          pat_next   = i_pattern;
          len_next   = eff_len;
          rep_next   = (i_repeat == '0) ? REP_ONE : i_repeat;
          bit_next   = IW'(eff_len - 1'b1);
          cyc_next   = '0;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (cyc_reg == BIT_LAST) begin
          cyc_next = '0;
          if (bit_reg != '0) begin
            bit_next = bit_reg - 1'b1;
          end else if (rep_reg <= REP_ONE) begin
            state_next = S_DONE;
          end else begin
            // Another pass: reload the index; with no gap the next bit follows immediately.
            rep_next = rep_reg - 1'b1;
            bit_next = bit_reload;
            if (GAP_CYCLES > 0) begin
              state_next = S_GAP;
            end
          end
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      S_GAP: begin
        if (cyc_reg == GAP_LAST) begin
          cyc_next   = '0;
          state_next = S_SEND;
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign o_valid = (state_reg == S_SEND);
  assign o_bit   = (state_reg == S_SEND) & pat_reg[bit_reg];
  assign o_busy  = (state_reg == S_SEND) || (state_reg == S_GAP);
  assign o_done  = (state_reg == S_DONE);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: default, gapped and single-cycle-bit instances.
module tb_seq_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (BIT_CYCLES=2, GAP_CYCLES=0)
  logic       a_rst, a_start;
  logic [7:0] a_pat;
  logic [3:0] a_len, a_rep;
  logic       a_bit, a_valid, a_busy, a_done;

  // Instance B: GAP_CYCLES=3
  logic       b_rst, b_start;
  logic [7:0] b_pat;
  logic [3:0] b_len, b_rep;
  logic       b_bit, b_valid, b_busy, b_done;

  // Instance C: BIT_CYCLES=1
  logic       c_rst, c_start;
  logic [7:0] c_pat;
  logic [3:0] c_len, c_rep;
  logic       c_bit, c_valid, c_busy, c_done;

  seq_pattern_gen u_a (
    .i_clock(clk), .i_reset(a_rst), .i_start(a_start), .i_pattern(a_pat),
    .i_len(a_len), .i_repeat(a_rep),
    .o_bit(a_bit), .o_valid(a_valid), .o_busy(a_busy), .o_done(a_done)
  );

  seq_pattern_gen #(.GAP_CYCLES(3)) u_b (
    .i_clock(clk), .i_reset(b_rst), .i_start(b_start), .i_pattern(b_pat),
    .i_len(b_len), .i_repeat(b_rep),
    .o_bit(b_bit), .o_valid(b_valid), .o_busy(b_busy), .o_done(b_done)
  );

  seq_pattern_gen #(.BIT_CYCLES(1)) u_c (
    .i_clock(clk), .i_reset(c_rst), .i_start(c_start), .i_pattern(c_pat),
    .i_len(c_len), .i_repeat(c_rep),
    .o_bit(c_bit), .o_valid(c_valid), .o_busy(c_busy), .o_done(c_done)
  );

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [3:0]  rep;
    logic [31:0] bits;   // expected serial stream, first bit at index n-1
    int          n;
    bit          disturb;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Compared as {busy, valid, bit, done}
  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: busy/valid/bit/done got %b expected %b", nm, got, exp);
  endtask

  function automatic logic [3:0] sa();
    return {a_busy, a_valid, a_bit, a_done};
  endfunction
  function automatic logic [3:0] sb();
    return {b_busy, b_valid, b_bit, b_done};
  endfunction
  function automatic logic [3:0] sc();
    return {c_busy, c_valid, c_bit, c_done};
  endfunction

  task automatic run_a(input vec_t v, input string nm);
    int bad0;
    bad0 = n_checks - n_pass;
    @(negedge clk);
    a_pat = v.pat; a_len = v.len; a_rep = v.rep; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int k = 0; k < v.n * 2; k++) begin
      chk({nm, " data"}, sa(), {1'b1, 1'b1, v.bits[v.n - 1 - k / 2], 1'b0});
      if (v.disturb && k == 4) begin
        a_start = 1'b1; a_pat = 8'hFF; a_len = 4'd8; a_rep = 4'd7;
      end
      if (v.disturb && k == 5) a_start = 1'b0;
      @(negedge clk);
    end
    chk({nm, " done"}, sa(), 4'b0001);
    @(negedge clk);
    chk({nm, " idle"}, sa(), 4'b0000);
    $display("%s: pat=%h len=%0d rep=%0d bits=%0d errors=%0d", nm, v.pat, v.len, v.rep,
             v.n, (n_checks - n_pass) - bad0);
  endtask

  // Gapped instance: passes of n_bits separated by 3 idle-but-busy cycles
  task automatic run_b(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep,
                       input logic [7:0] pass_bits, input int n, input int passes,
                       input string nm);
    int bad0;
    bad0 = n_checks - n_pass;
    @(negedge clk);
    b_pat = pat; b_len = len; b_rep = rep; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < n * 2; k++) begin
        chk({nm, " data"}, sb(), {1'b1, 1'b1, pass_bits[n - 1 - k / 2], 1'b0});
        @(negedge clk);
      end
      if (p != passes - 1) begin
        for (int g = 0; g < 3; g++) begin
          chk({nm, " gap"}, sb(), 4'b1000);
          @(negedge clk);
        end
      end
    end
    chk({nm, " done"}, sb(), 4'b0001);
    @(negedge clk);
    chk({nm, " idle"}, sb(), 4'b0000);
    $display("%s: pat=%h len=%0d rep=%0d errors=%0d", nm, pat, len, rep, (n_checks - n_pass) - bad0);
  endtask

  initial begin
    vecs[0] = '{8'h0A, 4'd4,  4'd3, 32'b1010_1010_1010,      12, 1'b0};
    vecs[1] = '{8'hB5, 4'd12, 4'd0, 32'b1011_0101,            8, 1'b0};
    vecs[2] = '{8'h01, 4'd1,  4'd2, 32'b11,                   2, 1'b0};
    vecs[3] = '{8'hFE, 4'd3,  4'd1, 32'b110,                  3, 1'b0};
    vecs[4] = '{8'h80, 4'd8,  4'd2, 32'h8080,                16, 1'b0};
    vecs[5] = '{8'h0A, 4'd4,  4'd3, 32'b1010_1010_1010,      12, 1'b1};

    a_rst = 1'b1; a_start = 1'b0; a_pat = '0; a_len = '0; a_rep = '0;
    b_rst = 1'b1; b_start = 1'b0; b_pat = '0; b_len = '0; b_rep = '0;
    c_rst = 1'b1; c_start = 1'b0; c_pat = '0; c_len = '0; c_rep = '0;
    repeat (3) @(negedge clk);
    chk("reset a", sa(), 4'b0000);
    chk("reset b", sb(), 4'b0000);
    chk("reset c", sc(), 4'b0000);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_a(vecs[i], $sformatf("vec%0d", i));
    end

    // Zero length start is ignored
    @(negedge clk);
    a_pat = 8'hFF; a_len = 4'd0; a_rep = 4'd3; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("len0", sa(), 4'b0000);
      @(negedge clk);
    end
    $display("len0: start with len=0 ignored");

    // Start held high through DONE: restart one cycle after DONE
    a_pat = 8'hFD; a_len = 4'd3; a_rep = 4'd1; a_start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk("held data1", sa(), {1'b1, 1'b1, (k / 2 == 1) ? 1'b0 : 1'b1, 1'b0});
      @(negedge clk);
    end
    chk("held done1", sa(), 4'b0001);
    @(negedge clk);
    chk("held idle", sa(), 4'b0000);
    @(negedge clk);
    a_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("held data2", sa(), {1'b1, 1'b1, (k / 2 == 1) ? 1'b0 : 1'b1, 1'b0});
      @(negedge clk);
    end
    chk("held done2", sa(), 4'b0001);
    @(negedge clk);
    chk("held idle2", sa(), 4'b0000);
    $display("held: start held through DONE restarts after one idle cycle");

    // Reset in the middle of a transfer
    a_pat = 8'h0A; a_len = 4'd4; a_rep = 4'd3; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("abort data", sa(), {1'b1, 1'b1, (k / 2 == 1) ? 1'b0 : 1'b1, 1'b0});
      if (k == 4) a_rst = 1'b1;
      @(negedge clk);
    end
    chk("abort reset", sa(), 4'b0000);
    a_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort no done", sa(), 4'b0000);
    end
    $display("abort: reset mid-transfer clears outputs, no done");
    run_a(vecs[0], "after_reset");

    // Gapped instance
    run_b(8'h0D, 4'd4, 4'd2, 8'b1101, 4, 2, "gap2");
    run_b(8'h02, 4'd2, 4'd1, 8'b10,   2, 1, "gap1");

    // Single-cycle bits, 15 back-to-back passes
    @(negedge clk);
    c_pat = 8'h01; c_len = 4'd1; c_rep = 4'd15; c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("bc1 data", sc(), 4'b1110);
      @(negedge clk);
    end
    chk("bc1 done", sc(), 4'b0001);
    @(negedge clk);
    chk("bc1 idle", sc(), 4'b0000);
    $display("bc1: 15 single-cycle passes");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
